// File: rtl/mp_cache_array_2p.sv
// mp_cache_array_2p: two-port cache SRAM model, port 0 masked read/write,
// port 1 read-only, zeroing sweep after reset, read-valid pulses, bypass.
module mp_cache_array_2p #(
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 4,
  parameter int WMASK_GRAN  = 8,
  parameter int BYPASS      = 1,
  parameter int WRITE_FIRST = 0,
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH,
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1,
  output logic                  busy
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_WIDTH:0] LAST =
    (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

  state_t state, state_nxt;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] bmask;
  logic [DATA_WIDTH-1:0] merged;
  logic rdy, we0, rd0, rd1, hit;

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NUM_WMASKS; i++)
      bmask[i*WMASK_GRAN +: WMASK_GRAN] =
        {WMASK_GRAN{wmask0[i]}};
  end

  assign merged = (mem[addr0] & ~bmask) | (din0 & bmask);
  assign rdy = (state == READY);
  assign we0 = rdy & ~csb0 & ~web0;
  assign rd0 = rdy & ~csb0 & web0;
  assign rd1 = rdy & ~csb1;
  assign hit = we0 && (addr0 == addr1) && (BYPASS != 0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:  if (cnt == LAST) state_nxt = READY;
      READY: state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == INIT);
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  // Array has no reset; the sweep clears it one word per edge.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (state == INIT)
        mem[cnt[ADDR_WIDTH-1:0]] <= '0;
      else if (we0)
        mem[addr0] <= merged;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0   <= '0;
      dout1   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= rd0 | (we0 & (WRITE_FIRST != 0));
      rvalid1 <= rd1;
      unique case (1'b1)
        rd0:                        dout0 <= mem[addr0];
        we0 && (WRITE_FIRST != 0):  dout0 <= merged;
        default:                    dout0 <= dout0;
      endcase
      if (rd1) dout1 <= hit ? merged : mem[addr1];
    end
  end

endmodule

// File: tb/tb_mp_cache_array_2p.sv
// tb_mp_cache_array_2p: random + directed checks of the two-port array
// against a word-level reference model; second instance reparametrised.
module tb_mp_cache_array_2p;

  logic         clk0 = 1'b0;
  logic         rst0;
  logic         csb0, web0, csb1;
  logic [31:0]  wmask0;
  logic [3:0]   addr0, addr1;
  logic [255:0] din0, dout0, dout1;
  logic         rvalid0, rvalid1, busy;

  logic         b_csb0, b_web0, b_csb1;
  logic [3:0]   b_wmask0;
  logic [5:0]   b_addr0, b_addr1;
  logic [63:0]  b_din0, b_dout0, b_dout1;
  logic         b_rvalid0, b_rvalid1, b_busy;

  always #5 clk0 = ~clk0;

  mp_cache_array_2p dut (
    .clk0(clk0), .rst0(rst0),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0), .rvalid0(rvalid0),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1), .rvalid1(rvalid1),
    .busy(busy)
  );

  mp_cache_array_2p #(
    .DATA_WIDTH(64), .ADDR_WIDTH(6), .WMASK_GRAN(16),
    .BYPASS(0), .WRITE_FIRST(1)
  ) dut2 (
    .clk0(clk0), .rst0(rst0),
    .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0),
    .addr0(b_addr0), .din0(b_din0),
    .dout0(b_dout0), .rvalid0(b_rvalid0),
    .csb1(b_csb1), .addr1(b_addr1),
    .dout1(b_dout1), .rvalid1(b_rvalid1),
    .busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [255:0] m_mem [16];
  logic [255:0] m_d0, m_d1;
  logic         m_rv0, m_rv1;
  int           m_left, b_left;

  task automatic chk(string tag, logic [255:0] got,
                     logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mmerge(logic [255:0] old,
    logic [255:0] d, logic [31:0] m);
    logic [255:0] r;
    r = old;
    for (int i = 0; i < 32; i++)
      if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance one edge: update the model from current inputs, then compare.
  task automatic step();
    logic [255:0] nw;
    if (rst0) begin
      m_left = 16; b_left = 64;
      m_d0 = '0; m_d1 = '0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    end else begin
      if (b_left > 0) b_left--;
      if (m_left > 0) begin
        m_mem[16 - m_left] = '0;
        m_left--;
        m_rv0 = 1'b0; m_rv1 = 1'b0;
      end else begin
        nw = mmerge(m_mem[addr0], din0, wmask0);
        m_rv1 = !csb1;
        if (!csb1)
          m_d1 = (!csb0 && !web0 && addr1 == addr0) ?
                 nw : m_mem[addr1];
        m_rv0 = !csb0 && web0;
        if (!csb0 && web0) m_d0 = m_mem[addr0];
        if (!csb0 && !web0) m_mem[addr0] = nw;
      end
    end
    @(posedge clk0); #1;
    chk("busy", 256'(busy), 256'(m_left > 0));
    chk("rvalid0", 256'(rvalid0), 256'(m_rv0));
    chk("rvalid1", 256'(rvalid1), 256'(m_rv1));
    chk("dout0", dout0, m_d0);
    chk("dout1", dout1, m_d1);
    chk("b_busy", 256'(b_busy), 256'(b_left > 0));
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0;
    addr0 = '0; din0 = '0; csb1 = 1'b1; addr1 = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    m_left = 16; b_left = 64;
    m_d0 = '0; m_d1 = '0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    idle();
    b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0;
    b_addr0 = '0; b_din0 = '0; b_csb1 = 1'b1; b_addr1 = '0;

    rst0 = 1'b1;
    step(); step();
    rst0 = 1'b0;

    for (int i = 0; i < 6; i++) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = '1;
      addr0 = 4'(i); din0 = rnd256();
      step();
    end
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = '1;
      addr0 = 4'(i); din0 = rnd256();
      csb1 = 1'b0; addr1 = 4'(15 - i);
      step();
    end
    chk("ready_after_16", 256'(busy), 256'(0));

    idle();
    for (int i = 0; i < 16; i++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(i);
      step();
      chk("init_zero", dout0, '0);
    end

    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3;
    din0 = {32{8'hAA}}; wmask0 = 32'h0000000F;
    step();
    web0 = 1'b1;
    step();
    chk("mask_aa", dout0, {224'b0, 32'hAAAAAAAA});
    web0 = 1'b0; din0 = {32{8'h55}}; wmask0 = 32'h00000003;
    step();
    web0 = 1'b1;
    step();
    chk("mask_55", dout0, {224'b0, 32'hAAAA5555});

    web0 = 1'b0; addr0 = 4'd5; din0 = {32{8'h11}}; wmask0 = '1;
    csb1 = 1'b0; addr1 = 4'd5;
    step();
    chk("bypass", dout1, {32{8'h11}});
    csb0 = 1'b1;
    step();
    chk("reread", dout1, {32{8'h11}});

    csb1 = 1'b1; csb0 = 1'b0; web0 = 1'b0;
    addr0 = 4'd2; din0 = {32{8'h3C}}; wmask0 = '1;
    step();
    web0 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      csb0 = 1'b0 ^ 1'b1;
      step();
      chk("hold_dout0", dout0, {32{8'h3C}});
      chk("hold_rv0", 256'(rvalid0), 256'(0));
    end

    for (int i = 0; i < 400; i++) begin
      csb0 = ($urandom_range(0, 3) == 0);
      web0 = 1'($urandom);
      wmask0 = $urandom;
      addr0 = 4'($urandom_range(0, 15));
      din0 = rnd256();
      csb1 = ($urandom_range(0, 3) == 0);
      addr1 = $urandom_range(0, 1) ? addr0 :
              4'($urandom_range(0, 15));
      step();
    end

    idle();
    b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = 6'd63;
    b_wmask0 = 4'b0100; b_din0 = 64'h1234_5678_9ABC_DEF0;
    step();
    chk("b_wfirst", 256'(b_dout0), 256'(64'h0000_5678_0000_0000));
    chk("b_wfirst_rv", 256'(b_rvalid0), 256'(1));
    b_web0 = 1'b1;
    step();
    chk("b_read63", 256'(b_dout0), 256'(64'h0000_5678_0000_0000));
    chk("b_read_rv", 256'(b_rvalid0), 256'(1));
    b_csb0 = 1'b1; b_csb1 = 1'b0; b_addr1 = 6'd63;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_hold", 256'(b_dout0), 256'(64'h0000_5678_0000_0000));
      chk("b_hold_rv", 256'(b_rvalid0), 256'(0));
    end
    chk("b_p1_read", 256'(b_dout1), 256'(64'h0000_5678_0000_0000));
    b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = 6'd5;
    b_wmask0 = 4'hF; b_din0 = {4{16'h1111}}; b_addr1 = 6'd5;
    step();
    chk("b_nobypass", 256'(b_dout1), 256'(0));
    chk("b_wf_full", 256'(b_dout0), 256'({4{16'h1111}}));
    b_csb0 = 1'b1;
    step();
    chk("b_reread", 256'(b_dout1), 256'({4{16'h1111}}));
    chk("b_rv1", 256'(b_rvalid1), 256'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
